// File: rtl/gate_tt_checker.sv
// Truth-table self-test engine for 2-input gates.
// Sweeps {a,b} through 00..11, samples gate_y after a settle delay, and records mismatches.
module gate_tt_checker #(
  parameter logic [3:0]  EXP_TT = 4'b0001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_d;
  logic [1:0] vec;
  logic [1:0] vec_d;
  logic [3:0] cnt;
  logic [3:0] cnt_d;
  logic [2:0] err_d;
  logic       fv_d;
  logic [1:0] fvec_d;
  logic       pass_d;
  logic       a_d;
  logic       b_d;
  logic       busy_d;
  logic       done_d;
  logic       mismatch;

  assign mismatch = (state == CHECK) && (gate_y != EXP_TT[vec]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 2'd0;
      cnt        <= 4'd0;
      err_count  <= 3'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      pass       <= 1'b0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      vec        <= vec_d;
      cnt        <= cnt_d;
      err_count  <= err_d;
      fail_valid <= fv_d;
      fail_vec   <= fvec_d;
      pass       <= pass_d;
      gate_a     <= a_d;
      gate_b     <= b_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) state_d = WAIT;
      end
      WAIT: begin
        if (cnt == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (vec == 2'd3) state_d = DONE;
        else             state_d = WAIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d  = vec;
    cnt_d  = cnt;
    err_d  = err_count;
    fv_d   = fail_valid;
    fvec_d = fail_vec;
    pass_d = pass;
    unique case (state)
      IDLE: begin
        if (start) begin
          vec_d  = 2'd0;
          cnt_d  = 4'd0;
          err_d  = 3'd0;
          fv_d   = 1'b0;
          fvec_d = 2'd0;
          pass_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt + 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_count + 3'd1;
          if (!fail_valid) begin
            fv_d   = 1'b1;
            fvec_d = vec;
          end
        end
        if (vec == 2'd3) begin
          pass_d = (err_d == 3'd0);
        end else begin
          vec_d = vec + 2'd1;
          cnt_d = 4'd0;
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  // Outputs are registered, so decode them from the upcoming state.
  always_comb begin
    busy_d = (state_d == WAIT) || (state_d == CHECK);
    done_d = (state_d == DONE);
    a_d    = 1'b0;
    b_d    = 1'b0;
    if (busy_d) begin
      a_d = vec_d[1];
      b_d = vec_d[0];
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker.
// Two instances: default NOR checker and a SETTLE=1 NAND checker.
module tb_gate_tt_checker;

  logic       clk;
  logic       rst;
  logic       start0;
  logic       start1;
  logic [1:0] mode;
  logic       y0;
  logic       y1;
  logic       a0, b0, busy0, done0, pass0, fv0;
  logic [2:0] err0;
  logic [1:0] fvec0;
  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] fvec1;

  int checks;
  int failures;

  gate_tt_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_y(y0),
    .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_valid(fv0),
    .fail_vec(fvec0)
  );

  gate_tt_checker #(.EXP_TT(4'b0111), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_y(y1),
    .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .fail_vec(fvec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    y0 = 1'b0;
    case (mode)
      2'd0: y0 = ~(a0 | b0);
      2'd1: y0 = a0 | b0;
      2'd2: y0 = 1'b1;
      default: y0 = 1'b0;
    endcase
    y1 = ~(a1 & b1);
  end

  task automatic pulse_start0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, fvec0} !== 11'd0) begin
      failures++;
      $display("FAIL reset0 got=%b want=0", {a0, b0, busy0, done0, pass0, err0, fv0, fvec0});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, fv1, fvec1} !== 11'd0) begin
      failures++;
      $display("FAIL reset1 got=%b want=0", {a1, b1, busy1, done1, pass1, err1, fv1, fvec1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nor_sweep;
    mode = 2'd0;
    pulse_start0();
    for (int n = 0; n < 12; n++) begin
      checks++;
      if ({a0, b0} !== 2'(n / 3) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        failures++;
        $display("FAIL nor_step n=%0d ab=%b busy=%b done=%b want ab=%0d busy=1 done=0", n, {a0, b0}, busy0, done0, n / 3);
      end
      @(negedge clk);
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 1'b1 || err0 !== 3'd0 || fv0 !== 1'b0 || {a0, b0} !== 2'b00) begin
      failures++;
      $display("FAIL nor_done done=%b busy=%b pass=%b err=%0d fv=%b ab=%b want 1 0 1 0 0 00", done0, busy0, pass0, err0, fv0, {a0, b0});
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || pass0 !== 1'b1) begin
      failures++;
      $display("FAIL nor_hold done=%b pass=%b want done=0 pass=1", done0, pass0);
    end
  endtask

  task automatic test_wrong_gate;
    int n;
    mode = 2'd1;
    pulse_start0();
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12) begin
      failures++;
      $display("FAIL or_latency got=%0d want=12", n);
    end
    checks++;
    if (pass0 !== 1'b0 || err0 !== 3'd4 || fv0 !== 1'b1 || fvec0 !== 2'b00) begin
      failures++;
      $display("FAIL or_result pass=%b err=%0d fv=%b fvec=%b want 0 4 1 00", pass0, err0, fv0, fvec0);
    end
    @(negedge clk);
  endtask

  task automatic test_stuck_then_clear;
    int n;
    mode = 2'd2;
    pulse_start0();
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12 || pass0 !== 1'b0 || err0 !== 3'd3 || fv0 !== 1'b1 || fvec0 !== 2'b01) begin
      failures++;
      $display("FAIL stuck n=%0d pass=%b err=%0d fv=%b fvec=%b want 12 0 3 1 01", n, pass0, err0, fv0, fvec0);
    end
    @(negedge clk);
    checks++;
    if (err0 !== 3'd3 || fvec0 !== 2'b01) begin
      failures++;
      $display("FAIL stuck_hold err=%0d fvec=%b want 3 01", err0, fvec0);
    end
    mode = 2'd0;
    pulse_start0();
    checks++;
    if (err0 !== 3'd0 || fv0 !== 1'b0 || pass0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL clear_on_start err=%0d fv=%b pass=%b busy=%b want 0 0 0 1", err0, fv0, pass0, busy0);
    end
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12 || pass0 !== 1'b1 || err0 !== 3'd0 || fv0 !== 1'b0) begin
      failures++;
      $display("FAIL rerun n=%0d pass=%b err=%0d fv=%b want 12 1 0 0", n, pass0, err0, fv0);
    end
    @(negedge clk);
  endtask

  task automatic test_nand_settle1;
    int n;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL nand_latency got=%0d want=8", n);
    end
    checks++;
    if (pass1 !== 1'b1 || err1 !== 3'd0 || fv1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL nand_result pass=%b err=%0d fv=%b busy=%b want 1 0 0 0", pass1, err1, fv1, busy1);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int first;
    int pulses;
    mode = 2'd0;
    pulse_start0();
    first = -1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      start0 = (n == 5);
      if (done0) begin
        pulses++;
        if (first < 0) first = n;
      end
      checks++;
      if (done0 === 1'b1 && busy0 === 1'b1) begin
        failures++;
        $display("FAIL done_busy_overlap n=%0d", n);
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++;
    if (pulses !== 1 || first !== 12) begin
      failures++;
      $display("FAIL ignore_start pulses=%0d first=%0d want 1 12", pulses, first);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int n;
    mode = 2'd0;
    pulse_start0();
    repeat (6) @(negedge clk);
    checks++;
    if ({a0, b0} !== 2'b10 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_vec ab=%b busy=%b want 10 1", {a0, b0}, busy0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, fvec0} !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b want=0", {a0, b0, busy0, done0, pass0, err0, fv0, fvec0});
    end
    pulses = 0;
    repeat (20) begin
      if (done0 || busy0) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_no_done activity=%0d want=0", pulses);
    end
    pulse_start0();
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 12 || pass0 !== 1'b1 || err0 !== 3'd0) begin
      failures++;
      $display("FAIL after_reset n=%0d pass=%b err=%0d want 12 1 0", n, pass0, err0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    int idle_seen;
    mode = 2'd0;
    start0 = 1'b1;
    @(negedge clk);
    d1 = -1;
    d2 = -1;
    idle_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done0) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 13 && !busy0 && !done0) idle_seen = 1;
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++;
    if (d1 !== 12 || d2 !== 26 || idle_seen !== 1) begin
      failures++;
      $display("FAIL back_to_back d1=%0d d2=%0d idle=%0d want 12 26 1", d1, d2, idle_seen);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    test_reset();
    test_nor_sweep();
    test_wrong_gate();
    test_stuck_then_clear();
    test_nand_settle1();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
